// File: rtl/core_bus_arb_pkg.sv
// rtl/core_bus_arb_pkg.sv - shared definitions for the core memory-bus arbiter
//
// Purpose: bus FSM state encodings and the master-count limit used by
//          core_bus_arb and core_bus_rr_pick.
// Ports:   none (package).
package core_bus_arb_pkg;

  localparam int MAX_M = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

endpackage

// File: rtl/core_bus_rr_pick.sv
// rtl/core_bus_rr_pick.sv - combinational winner picker for the bus arbiter
//
// Purpose: selects the first requesting master at or after a start pointer,
//          wrapping NUM_M-1 to 0. In fixed mode the pointer is forced to 0,
//          which degenerates to lowest-index-wins priority.
// Ports:
//   req_i        per-master request vector
//   ptr_i        round-robin start pointer
//   rr_mode_i    1 = round-robin, 0 = fixed priority
//   gnt_oh_o     one-hot grant (all zero when nobody requests)
//   gnt_idx_o    index of the granted master
//   gnt_valid_o  at least one request is present
module core_bus_rr_pick
  import core_bus_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IW    = 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  input  logic             rr_mode_i,
  output logic [NUM_M-1:0] gnt_oh_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             gnt_valid_o
);

  if (NUM_M < 2 || NUM_M > MAX_M) begin : g_bad_num_m
    $error("core_bus_rr_pick: NUM_M out of range");
  end

  int start_idx;
  int cand;

  always_comb begin
    gnt_oh_o    = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    start_idx   = rr_mode_i ? int'(ptr_i) : 0;
    cand        = 0;
    // Scan NUM_M candidates starting at the pointer; the pointer is always
    // below NUM_M, so one subtraction is enough to wrap.
    for (int i = 0; i < NUM_M; i++) begin
      cand = start_idx + i;
      if (cand >= NUM_M) begin
        cand = cand - NUM_M;
      end
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o    = 1'b1;
        gnt_idx_o      = IW'(cand);
        gnt_oh_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_bus_arb.sv
// rtl/core_bus_arb.sv - N-master to 1-slave memory-bus arbiter with timeout
//
// Purpose: arbitrates NUM_M core masters onto one req/ack memory slave,
//          with fixed-priority or round-robin selection and a slave timeout
//          that answers with an error pulse.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   m_req_i/we/addr/wdata per-master request fields (flattened, master k at k*W)
//   m_ack_o, m_err_o      one-cycle completion / timeout pulse to the grantee
//   m_rdata_o             shared read data, valid while an ack/err pulse is high
//   m_hold_o              per-master stall, m_req_i & ~(m_ack_o | m_err_o)
//   s_req_o/we/addr/wdata slave request, stable for the whole transaction
//   s_ack_i, s_rdata_i    slave completion and read data
module core_bus_arb
  import core_bus_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M*DW-1:0] m_wdata_i,
  output logic [NUM_M-1:0]    m_ack_o,
  output logic [NUM_M-1:0]    m_err_o,
  output logic [DW-1:0]       m_rdata_o,
  output logic [NUM_M-1:0]    m_hold_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [AW-1:0]       s_addr_o,
  output logic [DW-1:0]       s_wdata_o,
  input  logic                s_ack_i,
  input  logic [DW-1:0]       s_rdata_i
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  // Wide enough to hold TIMEOUT itself, so the counter cannot wrap before
  // it reaches the compare value.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_M - 1);

  bus_state_e       state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [NUM_M-1:0] gnt_oh_q, gnt_oh_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [NUM_M-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;

  core_bus_rr_pick #(
    .NUM_M(NUM_M),
    .IW   (IW)
  ) u_pick (
    .req_i      (m_req_i),
    .ptr_i      (ptr_q),
    .rr_mode_i  (RR_MODE != 0),
    .gnt_oh_o   (pick_oh),
    .gnt_idx_o  (pick_idx),
    .gnt_valid_o(pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          gnt_oh_d = pick_oh;
          we_d     = m_we_i[pick_idx];
          addr_d   = m_addr_i[pick_idx*AW +: AW];
          wdata_d  = m_wdata_i[pick_idx*DW +: DW];
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A slave ack in the same cycle as the timeout wins over the error.
        if (s_ack_i) begin
          rdata_d = s_rdata_i;
          ack_d   = 1'b1;
          state_d = ST_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        // No arbitration here: the grantee's request is still high this
        // cycle and must not win a second transaction.
        cnt_d = '0;
        if (RR_MODE != 0) begin
          ptr_d = (grant_q == IDX_LAST) ? '0 : grant_q + IW'(1);
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gnt_oh_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // ack_q/err_q are only ever set on entry to RESP, so these are the
  // one-cycle response pulses.
  assign m_ack_o   = ack_q ? gnt_oh_q : '0;
  assign m_err_o   = err_q ? gnt_oh_q : '0;
  assign m_rdata_o = rdata_q;
  assign m_hold_o  = m_req_i & ~(m_ack_o | m_err_o);

  assign s_req_o   = (state_q == ST_BUSY);
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;

endmodule

// File: tb/tb_core_bus_arb.sv
// tb/tb_core_bus_arb.sv - directed self-checking bench for core_bus_arb
module tb_core_bus_arb;

  logic clk;
  logic rst;

  // Instance A: 2 masters, fixed priority, default timeout.
  logic [1:0]  a_req, a_we, a_ack, a_err, a_hold;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
  logic        a_sreq, a_swe, a_sack;

  // Instance B: 3 masters, round-robin, timeout of 4.
  logic [2:0]  b_req, b_we, b_ack, b_err, b_hold;
  logic [95:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
  logic        b_sreq, b_swe, b_sack;

  int n_checks;
  int n_pass;

  int a_wait, b_wait;
  bit a_sen, b_sen;
  int a_scnt, b_scnt;

  int a_n_ack0, a_n_ack1, a_n_err, a_n_h1low, a_n_sreq, a_n_wcyc;
  int b_n_ack, b_n_err, b_n_err1, b_n_sreq, b_order;
  logic [31:0] b_err_rdata;

  core_bus_arb #(
    .NUM_M(2), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(255)
  ) dut_a (
    .clk(clk), .rst(rst),
    .m_req_i(a_req), .m_we_i(a_we), .m_addr_i(a_addr), .m_wdata_i(a_wdata),
    .m_ack_o(a_ack), .m_err_o(a_err), .m_rdata_o(a_rdata), .m_hold_o(a_hold),
    .s_req_o(a_sreq), .s_we_o(a_swe), .s_addr_o(a_saddr), .s_wdata_o(a_swdata),
    .s_ack_i(a_sack), .s_rdata_i(a_srdata)
  );

  core_bus_arb #(
    .NUM_M(3), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .m_req_i(b_req), .m_we_i(b_we), .m_addr_i(b_addr), .m_wdata_i(b_wdata),
    .m_ack_o(b_ack), .m_err_o(b_err), .m_rdata_o(b_rdata), .m_hold_o(b_hold),
    .s_req_o(b_sreq), .s_we_o(b_swe), .s_addr_o(b_saddr), .s_wdata_o(b_swdata),
    .s_ack_i(b_sack), .s_rdata_i(b_srdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave models: ack after *_wait BUSY cycles, i.e. in BUSY cycle wait+1.
  initial begin
    a_sack = 1'b0;
    a_scnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (a_sreq && a_sen) begin
        if (a_scnt == a_wait) begin
          a_sack = 1'b1;
        end else begin
          a_sack = 1'b0;
          a_scnt++;
        end
      end else begin
        a_sack = 1'b0;
        a_scnt = 0;
      end
    end
  end

  initial begin
    b_sack = 1'b0;
    b_scnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (b_sreq && b_sen) begin
        if (b_scnt == b_wait) begin
          b_sack = 1'b1;
        end else begin
          b_sack = 1'b0;
          b_scnt++;
        end
      end else begin
        b_sack = 1'b0;
        b_scnt = 0;
      end
    end
  end

  // Runs n cycles on instance A, sampling at negedge. Unless keep is set, a
  // master drops its request in the cycle after its ack/err pulse.
  task automatic a_run(input int n, input bit keep);
    logic [1:0] done;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      done = a_ack | a_err;
      if (a_ack[0]) a_n_ack0++;
      if (a_ack[1]) a_n_ack1++;
      if (a_err != 2'b00) a_n_err++;
      if (a_req[1] && !a_hold[1]) a_n_h1low++;
      if (a_sreq) a_n_sreq++;
      if (a_sreq && a_swe && a_swdata == 32'h55 && a_saddr == 32'h200) a_n_wcyc++;
      @(posedge clk);
      #1;
      if (!keep) a_req = a_req & ~done;
    end
  endtask

  task automatic b_run(input int n, input bit keep);
    logic [2:0] done;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      done = b_ack | b_err;
      if (b_ack != 3'b000) begin
        b_n_ack++;
        b_order = (b_order << 4) | (b_ack[1] ? 1 : (b_ack[2] ? 2 : 0));
      end
      if (b_err != 3'b000) begin
        b_n_err++;
        b_err_rdata = b_rdata;
      end
      if (b_err[1]) b_n_err1++;
      if (b_sreq) b_n_sreq++;
      @(posedge clk);
      #1;
      if (!keep) b_req = b_req & ~done;
    end
  endtask

  task automatic clear_stats();
    a_n_ack0 = 0; a_n_ack1 = 0; a_n_err = 0; a_n_h1low = 0; a_n_sreq = 0; a_n_wcyc = 0;
    b_n_ack = 0; b_n_err = 0; b_n_err1 = 0; b_n_sreq = 0; b_order = 0;
    b_err_rdata = 32'hFFFF_FFFF;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_srdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_srdata = '0;
    a_wait = 0; b_wait = 0; a_sen = 1'b1; b_sen = 1'b1;
    clear_stats();

    // Reset state; hold follows the request combinationally.
    a_req = 2'b10;
    #12;
    check("rst_a_sreq", 64'(a_sreq), 64'(0));
    check("rst_a_ack", 64'(a_ack), 64'(0));
    check("rst_a_err", 64'(a_err), 64'(0));
    check("rst_a_rdata", 64'(a_rdata), 64'(0));
    check("rst_a_hold", 64'(a_hold), 64'(2'b10));
    check("rst_b_sreq", 64'(b_sreq), 64'(0));
    a_req = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read, zero-wait slave.
    a_srdata = 32'hDEAD_BEEF;
    a_addr   = {32'h0000_0300, 32'h0000_0100};
    a_req    = 2'b01;
    @(negedge clk);
    check("rd_c0_hold", 64'(a_hold), 64'(2'b01));
    check("rd_c0_sreq", 64'(a_sreq), 64'(0));
    @(negedge clk);
    check("rd_c1_sreq", 64'(a_sreq), 64'(1));
    check("rd_c1_saddr", 64'(a_saddr), 64'(32'h100));
    check("rd_c1_hold", 64'(a_hold), 64'(2'b01));
    @(negedge clk);
    check("rd_c2_ack", 64'(a_ack), 64'(2'b01));
    check("rd_c2_rdata", 64'(a_rdata), 64'(32'hDEAD_BEEF));
    check("rd_c2_hold", 64'(a_hold), 64'(2'b00));
    @(posedge clk);
    #1;

    // Fixed priority with both masters requesting: master 0 always wins.
    clear_stats();
    a_req = 2'b11;
    a_run(9, 1'b1);
    a_req = 2'b00;
    check("fix_ack0", 64'(a_n_ack0), 64'(3));
    check("fix_ack1", 64'(a_n_ack1), 64'(0));
    check("fix_hold1_low", 64'(a_n_h1low), 64'(0));
    @(posedge clk);
    #1;

    // Write with 5 wait states: request fields stable for 6 cycles.
    clear_stats();
    a_we    = 2'b01;
    a_wdata = {32'h0, 32'h0000_0055};
    a_addr  = {32'h0, 32'h0000_0200};
    a_wait  = 5;
    a_req   = 2'b01;
    a_run(12, 1'b0);
    a_we = 2'b00;
    check("wr_stable_cyc", 64'(a_n_wcyc), 64'(6));
    check("wr_sreq_cyc", 64'(a_n_sreq), 64'(6));
    check("wr_ack_pulses", 64'(a_n_ack0), 64'(1));
    check("wr_err_pulses", 64'(a_n_err), 64'(0));

    // Round-robin with all three masters requesting.
    clear_stats();
    b_addr   = {32'h0000_2000, 32'h0000_1000, 32'h0000_0800};
    b_srdata = 32'hCAFE_0001;
    b_wait   = 0;
    b_req    = 3'b111;
    b_run(12, 1'b1);
    b_req = 3'b000;
    check("rr_order", 64'(b_order), 64'(32'h120));
    check("rr_acks", 64'(b_n_ack), 64'(4));
    @(posedge clk);
    #1;

    // Timeout: slave never answers.
    clear_stats();
    b_sen = 1'b0;
    b_req = 3'b010;
    b_run(10, 1'b0);
    b_sen = 1'b1;
    check("to_sreq_cyc", 64'(b_n_sreq), 64'(4));
    check("to_err1", 64'(b_n_err1), 64'(1));
    check("to_err_total", 64'(b_n_err), 64'(1));
    check("to_rdata", 64'(b_err_rdata), 64'(0));
    check("to_acks", 64'(b_n_ack), 64'(0));
    @(posedge clk);
    #1;

    // Reset in the middle of a wait-stated transaction (pointer was 2).
    b_wait = 3;
    b_req  = 3'b100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rstb_pre_sreq", 64'(b_sreq), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("rstb_sreq", 64'(b_sreq), 64'(0));
    check("rstb_ack", 64'(b_ack), 64'(0));
    check("rstb_saddr", 64'(b_saddr), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    b_wait = 0;
    b_req  = 3'b111;
    b_run(3, 1'b0);
    b_req = 3'b000;
    check("rstb_first_grant", 64'(b_order), 64'(0));
    check("rstb_acks", 64'(b_n_ack), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $fatal(1);
  end

endmodule

// File: doc/core_bus_arb.md
Name: core_bus_arb

Overview:
- Parametrised N-master to 1-slave memory-bus arbiter for the core, with a variable-latency slave.
- Replaces fixed per-port wiring between core stages (instruction fetch, load/store, future debug/DMA masters) and one shared memory port.
- Slave handshake is req/ack; masters get a one-cycle ack or error pulse.
- Adds selectable fixed-priority or round-robin arbitration, per-master stall outputs and a slave timeout with error response.

Parameters:
- NUM_M, 2, number of masters (2..8)
- AW, 32, address width
- DW, 32, data width
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
- TIMEOUT, 255, cycles in BUSY without s_ack_i before error; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m_req_i  in  NUM_M  per-master request; held high until that master's ack/err pulse
- m_we_i  in  NUM_M  per-master write enable
- m_addr_i  in  NUM_M*AW  flattened addresses; master k at [k*AW +: AW]
- m_wdata_i  in  NUM_M*DW  flattened write data
- m_ack_o  out  NUM_M  one-cycle completion pulse to the granted master
- m_err_o  out  NUM_M  one-cycle timeout-error pulse to the granted master
- m_rdata_o  out  DW  read data, shared; valid only while the corresponding ack is high
- m_hold_o  out  NUM_M  stall to the pipeline: m_req_i & ~(m_ack_o | m_err_o)
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_o  out  AW  slave address
- s_wdata_o  out  DW  slave write data
- s_ack_i  in  1  slave completion; may arrive in the first s_req_o cycle or later
- s_rdata_i  in  DW  slave read data, sampled when s_ack_i=1

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE, grant index=0, RR pointer=0, timeout counter=0.
  - All outputs 0. m_hold_o follows m_req_i combinationally.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If |m_req_i, pick a winner: fixed mode takes the lowest set index; RR mode takes the first set index at or after the pointer, wrapping NUM_M-1 to 0.
  - Register the winner index and its we/addr/wdata, then go to BUSY.
  - With no requests, stay in IDLE.
- BUSY:
  - s_req_o=1 with the latched fields, which stay stable for the whole transaction.
  - On s_ack_i: register s_rdata_i (a write returns the slave value, don't-care), set the ack flag, go to RESP.
  - Else, if TIMEOUT!=0 and the counter has reached TIMEOUT-1: set the err flag, rdata=0, go to RESP. s_req_o drops on that transition.
  - Else increment the counter.
- RESP (exactly one cycle):
  - Either m_ack_o[grant]=1 or m_err_o[grant]=1, never both. m_rdata_o is valid.
  - No arbitration happens in this cycle, so the still-high request is not re-granted.
  - RR mode: pointer = grant+1, wrapping at NUM_M.
  - Counter cleared; go to IDLE.
- Latency with a zero-wait slave (ack in first BUSY cycle):
  - req at cycle 0, s_req_o at cycle 1, m_ack_o at cycle 2.
  - Earliest next grant decision at cycle 3, so throughput is one transaction per 3 cycles minimum.
- Requests arriving or dropping during BUSY/RESP are ignored until IDLE.
- A master that drops req before its ack is a protocol violation; the transaction still completes on the slave side.
- s_ack_i outside BUSY is ignored.
- Counter width is clog2(TIMEOUT+1). It must not wrap before the compare.

Decomposition:
- Shared defines: bus state encodings (IDLE/BUSY/RESP) and the NUM_M maximum.
- Sub-module core_bus_rr_pick, combinational:
  - Inputs: req vector, start pointer, mode.
  - Outputs: one-hot grant and grant index.
  - Fixed mode forces the pointer to 0.
- FSM, latches and timeout live in core_bus_arb.

Test Plan:
- Single read, zero-wait slave.
  - Stimulus: m_req_i=01, addr0=0x100, s_ack_i returns s_rdata_i=0xDEADBEEF in the first s_req_o cycle.
  - Required: s_addr_o=0x100 at cycle 1; m_ack_o=01 and m_rdata_o=0xDEADBEEF at cycle 2; m_hold_o[0]=1 at cycles 0-1 and 0 at cycle 2.
- Fixed priority, RR_MODE=0.
  - Stimulus: m_req_i=11 held continuously.
  - Required: master 0 granted every transaction; m_hold_o[1] stays 1.
- Round-robin, RR_MODE=1, NUM_M=3.
  - Stimulus: m_req_i=111 held.
  - Required: grant order 0,1,2,0.
- Wait states on a write.
  - Stimulus: s_ack_i delayed 5 cycles, m_we_i=1, wdata=0x55.
  - Required: s_req_o, s_we_o and s_wdata_o=0x55 stable for 6 cycles; single m_ack_o pulse.
- Timeout.
  - Stimulus: TIMEOUT=4, s_ack_i never asserted.
  - Required: s_req_o high exactly 4 cycles; m_err_o pulse with m_rdata_o=0; m_ack_o stays 0.
- Reset mid-BUSY.
  - Stimulus: assert rst during a wait-stated transaction.
  - Required: s_req_o and m_ack_o go to 0 immediately (asynchronously); after release, a new request is arbitrated from IDLE with RR pointer=0.
